corner_locator: RTL

Frame-end scanner on the read side of the color-history SRAM. On a start pulse it reads all 640x480 4-bit history entries, {x[9:0], y[8:0]}. A pixel qualifies when its history count meets a threshold. The block tracks the bounding extrema of qualifying pixels and presents leftmost/rightmost/topmost/bottommost coordinates to the downstream corner-assembly logic over a valid/ready handshake.

---
 rtl/corner_locator_if.sv | 30 +++
 rtl/corner_locator.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/corner_locator_if.sv
// Handshake and SRAM read-port bundle between corner_locator and its environment.
// slave: the scanner itself; master: the frame controller / SRAM / corner-assembly side.
interface corner_locator_if;
    logic        start;
    logic [3:0]  hist_thresh;
    logic [18:0] mem_addr;
    logic        mem_rd_en;
    logic [3:0]  mem_rdata;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic        found;
    logic [9:0]  left_x;
    logic [9:0]  right_x;
    logic [9:0]  top_y;
    logic [9:0]  bottom_y;
    logic [18:0] pixel_count;

    modport master (
        output start, hist_thresh, mem_rdata, result_ready,
        input  mem_addr, mem_rd_en, busy, result_valid, found,
               left_x, right_x, top_y, bottom_y, pixel_count
    );

    modport slave (
        input  start, hist_thresh, mem_rdata, result_ready,
        output mem_addr, mem_rd_en, busy, result_valid, found,
               left_x, right_x, top_y, bottom_y, pixel_count
    );
endinterface

// File: rtl/corner_locator.sv
// Frame-end scanner: bounding box (and optional count) of pixels whose history meets a threshold.
// Optional qualifying-pixel counter built when CORNER_LOCATOR_COUNT_EN is defined.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; no reads issued
// S_SCAN  | one read per cycle, y inner loop, x outer loop
// S_DRAIN | last datum returns, then outputs registered from accumulators
// S_DONE  | result_valid held until result_ready
module corner_locator #(
    parameter int H_PIXELS = 640,
    parameter int V_PIXELS = 480
) (
    input logic              clk,
    input logic              reset,
    corner_locator_if.slave  bus
);
    localparam logic [9:0] X_LAST = 10'(H_PIXELS - 1);
    localparam logic [8:0] Y_LAST = 9'(V_PIXELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [3:0]  thresh_q, thresh_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        rd_en_q, rd_en_d;
    logic [9:0]  tag_x_q, tag_x_d;
    logic [8:0]  tag_y_q, tag_y_d;
    logic        tag_v_q, tag_v_d;
    logic [9:0]  min_x_q, min_x_d, max_x_q, max_x_d;
    logic [8:0]  min_y_q, min_y_d, max_y_q, max_y_d;
    logic        hit_q, hit_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        found_q, found_d;
    logic [9:0]  left_q, left_d, right_q, right_d, top_q, top_d, bottom_q, bottom_d;
    logic        qualify;
`ifdef CORNER_LOCATOR_COUNT_EN
    logic [18:0] cnt_q, cnt_d, pcount_q, pcount_d;
`endif

    // Tag stage lines up with the SRAM's one-cycle read latency.
    assign qualify = tag_v_q && (bus.mem_rdata >= thresh_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            thresh_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            rd_en_q  <= 1'b0;
            tag_x_q  <= '0;
            tag_y_q  <= '0;
            tag_v_q  <= 1'b0;
            min_x_q  <= X_LAST;
            max_x_q  <= '0;
            min_y_q  <= Y_LAST;
            max_y_q  <= '0;
            hit_q    <= 1'b0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            found_q  <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
            top_q    <= '0;
            bottom_q <= '0;
`ifdef CORNER_LOCATOR_COUNT_EN
            cnt_q    <= '0;
            pcount_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            thresh_q <= thresh_d;
            x_q      <= x_d;
            y_q      <= y_d;
            rd_en_q  <= rd_en_d;
            tag_x_q  <= tag_x_d;
            tag_y_q  <= tag_y_d;
            tag_v_q  <= tag_v_d;
            min_x_q  <= min_x_d;
            max_x_q  <= max_x_d;
            min_y_q  <= min_y_d;
            max_y_q  <= max_y_d;
            hit_q    <= hit_d;
            busy_q   <= busy_d;
            valid_q  <= valid_d;
            found_q  <= found_d;
            left_q   <= left_d;
            right_q  <= right_d;
            top_q    <= top_d;
            bottom_q <= bottom_d;
`ifdef CORNER_LOCATOR_COUNT_EN
            cnt_q    <= cnt_d;
            pcount_q <= pcount_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        thresh_d = thresh_q;
        x_d      = x_q;
        y_d      = y_q;
        rd_en_d  = rd_en_q;
        tag_x_d  = x_q;
        tag_y_d  = y_q;
        tag_v_d  = rd_en_q;
        min_x_d  = min_x_q;
        max_x_d  = max_x_q;
        min_y_d  = min_y_q;
        max_y_d  = max_y_q;
        hit_d    = hit_q;
        busy_d   = busy_q;
        valid_d  = valid_q;
        found_d  = found_q;
        left_d   = left_q;
        right_d  = right_q;
        top_d    = top_q;
        bottom_d = bottom_q;
`ifdef CORNER_LOCATOR_COUNT_EN
        cnt_d    = cnt_q;
        pcount_d = pcount_q;
`endif

        if (qualify) begin
            if (tag_x_q < min_x_q) min_x_d = tag_x_q;
            if (tag_x_q > max_x_q) max_x_d = tag_x_q;
            if (tag_y_q < min_y_q) min_y_d = tag_y_q;
            if (tag_y_q > max_y_q) max_y_d = tag_y_q;
            hit_d = 1'b1;
`ifdef CORNER_LOCATOR_COUNT_EN
            cnt_d = cnt_q + 19'd1;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    thresh_d = bus.hist_thresh;
                    min_x_d  = X_LAST;
                    max_x_d  = '0;
                    min_y_d  = Y_LAST;
                    max_y_d  = '0;
                    hit_d    = 1'b0;
`ifdef CORNER_LOCATOR_COUNT_EN
                    cnt_d    = '0;
`endif
                    x_d      = '0;
                    y_d      = '0;
                    rd_en_d  = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                if (x_q == X_LAST && y_q == Y_LAST) begin
                    x_d     = '0;
                    y_d     = '0;
                    rd_en_d = 1'b0;
                    state_d = S_DRAIN;
                end else if (y_q == Y_LAST) begin
                    y_d = '0;
                    x_d = x_q + 10'd1;
                end else begin
                    y_d = y_q + 9'd1;
                end
            end
            S_DRAIN: begin
                // Wait until the final tagged datum has been folded in.
                if (!tag_v_q) begin
                    found_d  = hit_q;
                    left_d   = hit_q ? min_x_q : 10'd0;
                    right_d  = hit_q ? max_x_q : 10'd0;
                    top_d    = hit_q ? {1'b0, min_y_q} : 10'd0;
                    bottom_d = hit_q ? {1'b0, max_y_q} : 10'd0;
`ifdef CORNER_LOCATOR_COUNT_EN
                    pcount_d = cnt_q;
`endif
                    valid_d  = 1'b1;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (valid_q && bus.result_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.mem_addr     = {x_q, y_q};
    assign bus.mem_rd_en    = rd_en_q;
    assign bus.busy         = busy_q;
    assign bus.result_valid = valid_q;
    assign bus.found        = found_q;
    assign bus.left_x       = left_q;
    assign bus.right_x      = right_q;
    assign bus.top_y        = top_q;
    assign bus.bottom_y     = bottom_q;
`ifdef CORNER_LOCATOR_COUNT_EN
    assign bus.pixel_count  = pcount_q;
`else
    assign bus.pixel_count  = '0;
`endif
endmodule
